pong_engine: RTL and testbench

//  Parametrised two-player pong game engine in the VGA pixel domain. Per-frame ball physics,

---
 rtl/pong_pkg.sv | 20 ++
 rtl/pong_ball.sv | 115 +++++++++++
 rtl/pong_engine.sv | 168 ++++++++++++++++
 tb/tb_pong_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types for the pong engine: FSM encoding, RGB colours and scan-coordinate width.
package pong_pkg;
    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2
    } state_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    function automatic coord_t clamp_max(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/pong_ball.sv
// Ball position/direction state; steps once per PLAY frame, reflects off walls and paddles, flags misses.
// Miss flags are combinational and only meaningful while step_en is high; no backpressure.
module pong_ball
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 50,
    parameter int PADDLE_INSET = 10,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step_en,
    input  logic   serve_load,
    input  coord_t paddle_l_y,
    input  coord_t paddle_r_y,
    output coord_t ball_x,
    output coord_t ball_y,
    output logic   miss_l,
    output logic   miss_r
);
    localparam coord_t STEP     = coord_t'(BALL_SPEED);
    localparam coord_t BALL_SZ  = coord_t'(BALL_SIZE);
    localparam coord_t PAD_H    = coord_t'(PADDLE_H);
    localparam coord_t X_CENTRE = coord_t'((H_ACTIVE - BALL_SIZE) / 2);
    localparam coord_t Y_CENTRE = coord_t'((V_ACTIVE - BALL_SIZE) / 2);
    localparam coord_t X_MAX    = coord_t'(H_ACTIVE - BALL_SIZE);
    localparam coord_t Y_MAX    = coord_t'(V_ACTIVE - BALL_SIZE);
    localparam coord_t L_STOP   = coord_t'(PADDLE_INSET + PADDLE_W);
    localparam coord_t R_STOP   = coord_t'(H_ACTIVE - PADDLE_INSET - PADDLE_W - BALL_SIZE);

    coord_t x_q, x_d, y_q, y_d, y_nx;
    logic   dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d, dy_nx;
    logic   hit_l, hit_r;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        miss_l   = 1'b0;
        miss_r   = 1'b0;
        y_nx     = y_q;
        dy_nx    = dy_neg_q;

        // Magnitude compares stand in for signed x/y_next so nothing underflows past 0.
        if (dy_neg_q) begin
            if (y_q <= STEP) begin
                y_nx  = '0;
                dy_nx = 1'b0;
            end else begin
                y_nx = y_q - STEP;
            end
        end else if (y_q + STEP >= Y_MAX) begin
            y_nx  = Y_MAX;
            dy_nx = 1'b1;
        end else begin
            y_nx = y_q + STEP;
        end

        hit_l = (y_nx + BALL_SZ > paddle_l_y) && (y_nx < paddle_l_y + PAD_H);
        hit_r = (y_nx + BALL_SZ > paddle_r_y) && (y_nx < paddle_r_y + PAD_H);

        if (serve_load) begin
            // dx is left untouched: it already points at the side that conceded.
            x_d      = X_CENTRE;
            y_d      = Y_CENTRE;
            dy_neg_d = 1'b0;
        end else if (step_en) begin
            y_d      = y_nx;
            dy_neg_d = dy_nx;
            if (dx_neg_q) begin
                if (x_q <= L_STOP + STEP && hit_l) begin
                    x_d      = L_STOP;
                    dx_neg_d = 1'b0;
                end else if (x_q <= STEP) begin
                    x_d    = '0;
                    miss_l = 1'b1;
                end else begin
                    x_d = x_q - STEP;
                end
            end else begin
                if (x_q + STEP >= R_STOP && hit_r) begin
                    x_d      = R_STOP;
                    dx_neg_d = 1'b1;
                end else if (x_q + STEP >= X_MAX) begin
                    x_d    = X_MAX;
                    miss_r = 1'b1;
                end else begin
                    x_d = x_q + STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= X_CENTRE;
            y_q      <= Y_CENTRE;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
        end
    end

    assign ball_x = x_q;
    assign ball_y = y_q;
endmodule

// File: rtl/pong_engine.sv
// Two-player pong engine on VGA scan coordinates; PIXEL registered one cycle after PIXEL_H/V, no backpressure.
// Build option PONG_AI_PADDLE_EN: right paddle follows the ball instead of PADDLE_POSITION_R.
module pong_engine
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 50,
    parameter int PADDLE_INSET = 10,
    parameter int PADDLE_SHIFT = 1,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30,
    parameter int SCORE_W      = 4
) (
    input  logic               VGA_CLOCK,
    input  logic               RESET,
    input  logic [7:0]         PADDLE_POSITION_L,
    input  logic [7:0]         PADDLE_POSITION_R,
    input  logic [COORD_W-1:0] PIXEL_H,
    input  logic [COORD_W-1:0] PIXEL_V,
    output logic [2:0]         PIXEL,
    output logic [SCORE_W-1:0] SCORE_L,
    output logic [SCORE_W-1:0] SCORE_R,
    output logic               IN_PLAY
);
    localparam int     CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int     CNT_W   = $clog2(CNT_MAX + 1);
    localparam coord_t PAD_MAX = coord_t'(V_ACTIVE - PADDLE_H);
    localparam coord_t PAD_H   = coord_t'(PADDLE_H);
    localparam coord_t BALL_SZ = coord_t'(BALL_SIZE);
    localparam coord_t L_COL   = coord_t'(PADDLE_INSET);
    localparam coord_t R_COL   = coord_t'(H_ACTIVE - PADDLE_INSET - PADDLE_W);
    localparam coord_t PAD_W   = coord_t'(PADDLE_W);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    coord_t             pad_l_q, pad_l_d, pad_r_q, pad_r_d;
    logic [2:0]         pixel_q, pixel_d;
    coord_t             ball_x, ball_y;
    logic               frame_tick, step_en, serve_load, miss_l, miss_r;
    logic               in_active, on_border, on_ball, on_pad_l, on_pad_r, flash;

    assign frame_tick = (PIXEL_H == '0) && (PIXEL_V == coord_t'(V_ACTIVE));
    assign step_en    = frame_tick && (state_q == PLAY);
    assign serve_load = frame_tick && (state_q == MISS) && (cnt_q == CNT_W'(MISS_FRAMES - 1));

    // The ball sees the freshly sampled paddle rows in the same tick they are latched.
    assign pad_l_d = frame_tick ? clamp_max(coord_t'(PADDLE_POSITION_L) << PADDLE_SHIFT, PAD_MAX) : pad_l_q;

`ifdef PONG_AI_PADDLE_EN
    localparam coord_t AI_STEP  = coord_t'((BALL_SPEED > 1) ? BALL_SPEED - 1 : 1);
    localparam coord_t HALF_GAP = coord_t'((PADDLE_H - BALL_SIZE) / 2);
    coord_t ai_target;

    always_comb begin
        ai_target = (ball_y > HALF_GAP) ? clamp_max(ball_y - HALF_GAP, PAD_MAX) : '0;
        pad_r_d   = pad_r_q;
        if (frame_tick) begin
            if (ai_target > pad_r_q + AI_STEP) begin
                pad_r_d = pad_r_q + AI_STEP;
            end else if (ai_target + AI_STEP < pad_r_q) begin
                pad_r_d = pad_r_q - AI_STEP;
            end else begin
                pad_r_d = ai_target;
            end
        end
    end
`else
    assign pad_r_d = frame_tick ? clamp_max(coord_t'(PADDLE_POSITION_R) << PADDLE_SHIFT, PAD_MAX) : pad_r_q;
`endif

    pong_ball #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
        .PADDLE_INSET(PADDLE_INSET), .BALL_SIZE(BALL_SIZE), .BALL_SPEED(BALL_SPEED)
    ) u_ball (
        .clk(VGA_CLOCK), .rst_n(RESET), .step_en(step_en), .serve_load(serve_load),
        .paddle_l_y(pad_l_d), .paddle_r_y(pad_r_d),
        .ball_x(ball_x), .ball_y(ball_y), .miss_l(miss_l), .miss_r(miss_r)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        if (frame_tick) begin
            case (state_q)
                SERVE: begin
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PLAY: begin
                    if (miss_l || miss_r) begin
                        state_d = MISS;
                        cnt_d   = '0;
                    end
                    if (miss_l && score_r_q != '1) score_r_d = score_r_q + 1'b1;
                    if (miss_r && score_l_q != '1) score_l_d = score_l_q + 1'b1;
                end
                MISS: begin
                    if (cnt_q == CNT_W'(MISS_FRAMES - 1)) begin
                        state_d = SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_active = (PIXEL_H < coord_t'(H_ACTIVE)) && (PIXEL_V < coord_t'(V_ACTIVE));
        on_border = (PIXEL_V == '0) || (PIXEL_V == coord_t'(V_ACTIVE - 1)) ||
                    (PIXEL_H == '0) || (PIXEL_H == coord_t'(H_ACTIVE - 1));
        on_ball   = (PIXEL_H >= ball_x) && (PIXEL_H < ball_x + BALL_SZ) &&
                    (PIXEL_V >= ball_y) && (PIXEL_V < ball_y + BALL_SZ);
        on_pad_l  = (PIXEL_H >= L_COL) && (PIXEL_H < L_COL + PAD_W) &&
                    (PIXEL_V >= pad_l_q) && (PIXEL_V < pad_l_q + PAD_H);
        on_pad_r  = (PIXEL_H >= R_COL) && (PIXEL_H < R_COL + PAD_W) &&
                    (PIXEL_V >= pad_r_q) && (PIXEL_V < pad_r_q + PAD_H);
        // Odd frames of the miss pause, counted from the tick that entered MISS.
        flash     = (state_q == MISS) && cnt_q[0];

        pixel_d = BLACK;
        if (!in_active)              pixel_d = BLACK;
        else if (on_border)          pixel_d = RED;
        else if (on_ball)            pixel_d = flash ? RED : WHITE;
        else if (on_pad_l || on_pad_r) pixel_d = WHITE;
    end

    always_ff @(posedge VGA_CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= SERVE;
            cnt_q     <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            pad_l_q   <= '0;
            pad_r_q   <= '0;
            pixel_q   <= BLACK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            pad_l_q   <= pad_l_d;
            pad_r_q   <= pad_r_d;
            pixel_q   <= pixel_d;
        end
    end

    assign PIXEL   = pixel_q;
    assign SCORE_L = score_l_q;
    assign SCORE_R = score_r_q;
    assign IN_PLAY = (state_q == PLAY);
endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: reset/render vector table, directed serve/rally/miss/saturation/reset sequences,
// and randomised paddle play, all scored against a behavioural game model.
module tb_pong_engine;
    localparam int H = 640, V = 480, PW = 10, PH = 50, INSET = 10, B = 8, SPD = 2;
    localparam int SERVE_N = 60, MISS_N = 30, SMAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pl, pr;
    logic [10:0] ph, pv;
    logic [2:0]  pixel;
    logic [3:0]  score_l, score_r;
    logic        in_play;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural game model: signed integer positions, direction as +1/-1.
    int m_bx, m_by, m_dx, m_dy, m_st, m_cnt, m_sl, m_sr, m_ply, m_pry, m_hits_l;
    bit m_sat_seen;

    pong_engine dut (
        .VGA_CLOCK(clk), .RESET(rst_n),
        .PADDLE_POSITION_L(pl), .PADDLE_POSITION_R(pr),
        .PIXEL_H(ph), .PIXEL_V(pv),
        .PIXEL(pixel), .SCORE_L(score_l), .SCORE_R(score_r), .IN_PLAY(in_play)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_bx = (H - B) / 2; m_by = (V - B) / 2; m_dx = 1; m_dy = 1;
        m_st = 0; m_cnt = 0; m_sl = 0; m_sr = 0; m_ply = 0; m_pry = 0;
        m_hits_l = 0; m_sat_seen = 0;
    endtask

    task automatic m_tick(input int pli, input int pri);
        int nx, ny;
        bit ovl, ovr;
        m_ply = (pli * 2 > V - PH) ? V - PH : pli * 2;
        m_pry = (pri * 2 > V - PH) ? V - PH : pri * 2;
        if (m_st == 0) begin
            m_cnt++;
            if (m_cnt == SERVE_N) begin m_st = 1; m_cnt = 0; end
        end else if (m_st == 1) begin
            ny = m_by + m_dy * SPD;
            if (ny <= 0) begin ny = 0; m_dy = 1; end
            else if (ny >= V - B) begin ny = V - B; m_dy = -1; end
            nx = m_bx + m_dx * SPD;
            ovl = (ny + B > m_ply) && (ny < m_ply + PH);
            ovr = (ny + B > m_pry) && (ny < m_pry + PH);
            if (m_dx < 0 && nx <= INSET + PW && ovl) begin
                nx = INSET + PW; m_dx = 1; m_hits_l++;
            end else if (m_dx < 0 && nx <= 0) begin
                nx = 0;
                if (m_sr == SMAX) m_sat_seen = 1; else m_sr++;
                m_st = 2; m_cnt = 0;
            end else if (m_dx > 0 && nx + B >= H - INSET - PW && ovr) begin
                nx = H - INSET - PW - B; m_dx = -1;
            end else if (m_dx > 0 && nx + B >= H) begin
                nx = H - B;
                if (m_sl != SMAX) m_sl++;
                m_st = 2; m_cnt = 0;
            end
            m_bx = nx; m_by = ny;
        end else begin
            m_cnt++;
            if (m_cnt == MISS_N) begin
                m_st = 0; m_cnt = 0; m_bx = (H - B) / 2; m_by = (V - B) / 2; m_dy = 1;
            end
        end
    endtask

    function automatic int m_pix(input int h, input int v);
        if (h >= H || v >= V) return 0;
        if (h == 0 || v == 0 || h == H - 1 || v == V - 1) return 4;
        if (h >= m_bx && h < m_bx + B && v >= m_by && v < m_by + B)
            return (m_st == 2 && (m_cnt % 2) == 1) ? 4 : 7;
        if (h >= INSET && h < INSET + PW && v >= m_ply && v < m_ply + PH) return 7;
        if (h >= H - INSET - PW && h < H - INSET && v >= m_pry && v < m_pry + PH) return 7;
        return 0;
    endfunction

    function automatic int track();
        int p;
        p = m_by + B / 2 - PH / 2;
        if (p < 0) p = 0;
        return p / 2;
    endfunction

    function automatic int avoid();
        return (m_by < V / 2) ? 255 : 0;
    endfunction

    task automatic do_tick(input int pli, input int pri);
        @(negedge clk);
        pl = 8'(pli); pr = 8'(pri); ph = 11'd0; pv = 11'(V);
        @(negedge clk);
        ph = 11'd1; pv = 11'd0;
        m_tick(pli, pri);
        chk("score_l", int'(score_l), m_sl);
        chk("score_r", int'(score_r), m_sr);
        chk("in_play", int'(in_play), int'(m_st == 1));
    endtask

    task automatic probe(input string name, input int h, input int v, input int exp);
        @(negedge clk);
        ph = 11'(h); pv = 11'(v);
        @(negedge clk);
        chk(name, int'(pixel), exp);
    endtask

    task automatic tick_chk(input int pli, input int pri);
        do_tick(pli, pri);
        probe("ball_px", m_bx + 1, m_by + 1, m_pix(m_bx + 1, m_by + 1));
        probe("ball_edge_px", m_bx + B, m_by + 4, m_pix(m_bx + B, m_by + 4));
    endtask

    vec_t rst_vecs[$];

    initial begin
        rst_vecs = '{
            '{0, 0, 4},     '{639, 240, 4}, '{320, 479, 4}, '{0, 200, 4},
            '{640, 10, 0},  '{100, 480, 0}, '{316, 236, 7}, '{323, 243, 7},
            '{324, 243, 0}, '{316, 244, 0}, '{315, 240, 0}, '{10, 1, 7},
            '{19, 49, 7},   '{20, 25, 0},   '{10, 50, 0},   '{629, 30, 7},
            '{630, 30, 0},  '{619, 30, 0},  '{200, 200, 0}
        };

        rst_n = 1'b0; pl = 8'd0; pr = 8'd0; ph = 11'd1; pv = 11'd0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_score_r", int'(score_r), 0);
        chk("rst_in_play", int'(in_play), 0);
        rst_n = 1'b1;

        foreach (rst_vecs[i]) probe($sformatf("render_%0d_%0d", rst_vecs[i].h, rst_vecs[i].v),
                                    rst_vecs[i].h, rst_vecs[i].v, rst_vecs[i].exp);

        // Serve countdown with the left paddle input saturated high.
        for (int i = 0; i < SERVE_N; i++) begin
            do_tick(255, 0);
            chk("serve_in_play", int'(in_play), (i == SERVE_N - 1) ? 1 : 0);
            if (i == 0) begin
                probe("padl_top", 10, 430, 7);
                probe("padl_low", 19, 478, 7);
                probe("padl_border", 15, 479, 4);
                probe("padl_above", 10, 429, 0);
                probe("padl_right", 20, 450, 0);
                probe("padl_left", 5, 450, 0);
            end
        end

        // Rally: both paddles follow the ball until the left paddle has returned it twice.
        for (int g = 0; g < 1500 && m_hits_l < 2; g++) tick_chk(track(), track());
        chk("rally_left_hits", m_hits_l >= 2 ? 1 : 0, 1);
        chk("rally_no_score_r", int'(score_r), 0);
        chk("rally_no_score_l", int'(score_l), 0);

        // Left paddle dodges the ball: left miss.
        for (int g = 0; g < 1000 && m_st != 2; g++) tick_chk(avoid(), track());
        chk("miss_score_r", int'(score_r), 1);
        chk("miss_in_play", int'(in_play), 0);
        for (int k = 1; k <= MISS_N; k++) begin
            do_tick(0, 0);
            if (k < MISS_N) probe("miss_flash", m_bx + 1, m_by + 1, (k % 2 == 1) ? 4 : 7);
        end
        for (int k = 0; k < SERVE_N; k++) do_tick(0, 0);
        do_tick(0, 0);
        probe("serve_dx_neg_ball", 314, 238, 7);
        probe("serve_dx_neg_trail", 322, 238, 0);

        // Random paddles.
        for (int g = 0; g < 300; g++) tick_chk($urandom_range(0, 255), $urandom_range(0, 255));

        // Drive SCORE_R into saturation, then one more left miss.
        for (int g = 0; g < 9000 && !m_sat_seen; g++) do_tick(avoid(), track());
        chk("score_r_saturated", int'(score_r), 15);
        chk("saturation_miss_seen", int'(m_sat_seen), 1);

        // Asynchronous reset in the middle of play.
        for (int g = 0; g < 200 && m_st != 1; g++) do_tick(track(), track());
        probe("pre_reset_ball", m_bx + 1, m_by + 1, 7);
        chk("pre_reset_in_play", int'(in_play), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pixel", int'(pixel), 0);
        chk("midrst_score_l", int'(score_l), 0);
        chk("midrst_score_r", int'(score_r), 0);
        chk("midrst_in_play", int'(in_play), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < SERVE_N; i++) begin
            tick_chk(100, 100);
            chk("reserve_in_play", int'(in_play), (i == SERVE_N - 1) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
